// File: rtl/integer_lane_pipelined.sv
// Integer execution lane: dispatch handshake, PIPE_DEPTH execute stages, result FIFO with credit-based admission.
// Optional multiplier opcodes 12-15 are built only when INTEGER_LANE_MUL_EN is defined.
module integer_lane_pipelined #(
  parameter int XLEN                = 32,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 8,
  parameter int PIPE_DEPTH          = 2,
  parameter int OUT_FIFO_DEPTH      = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [XLEN-1:0]                dispatch_1st_reg,
  input  logic [XLEN-1:0]                dispatch_2nd_reg,
  input  logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction,
  input  logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index,
  input  logic [XLEN-1:0]                dispatch_PC_i,
  input  logic                           execute_ready,
  output logic                           execute_valid,
  output logic [ROB_INDEX_WIDTH-1:0]     execute_ROB_index,
  output logic [XLEN-1:0]                execute_value,
  input  logic                           flush
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int OCC_W = $clog2(OUT_FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(OUT_FIFO_DEPTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SLL  = 4'd1,  OP_SLT   = 4'd2,  OP_SLTU   = 4'd3,
    OP_XOR  = 4'd4,  OP_SRL  = 4'd5,  OP_OR    = 4'd6,  OP_AND    = 4'd7,
    OP_SUB  = 4'd8,  OP_SRA  = 4'd9,  OP_LUI   = 4'd10, OP_AUIPC  = 4'd11,
    OP_MUL  = 4'd12, OP_MULH = 4'd13, OP_MULHU = 4'd14, OP_MULHSU = 4'd15
  } opcode_e;

  opcode_e              opcode;
  logic [XLEN-1:0]      opA;
  logic [XLEN-1:0]      opB;
  logic [SH_W-1:0]      shiftAmount;
  logic [XLEN-1:0]      aluResult;
  logic                 accept;
  logic                 pop;
  logic                 fifoWrite;
  logic                 fifoEmpty;
  logic                 headValid;
  logic                 unusedOpcodeBits;

  logic [PIPE_DEPTH-1:0]      stageValid_q;
  logic [ROB_INDEX_WIDTH-1:0] stageTag_q   [PIPE_DEPTH];
  logic [XLEN-1:0]            stageValue_q [PIPE_DEPTH];
  logic [ROB_INDEX_WIDTH-1:0] fifoTag_q    [OUT_FIFO_DEPTH];
  logic [XLEN-1:0]            fifoValue_q  [OUT_FIFO_DEPTH];
  logic [PTR_W:0]             wrPtr_q, wrPtr_d;
  logic [PTR_W:0]             rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]           occ_q, occ_d;

  assign opcode           = opcode_e'(dispatch_decoded_instruction[3:0]);
  assign unusedOpcodeBits = ^dispatch_decoded_instruction[DECODED_INSTR_WIDTH-1:4];
  assign opA              = dispatch_1st_reg;
  assign opB              = dispatch_2nd_reg;
  assign shiftAmount      = opB[SH_W-1:0];

`ifdef INTEGER_LANE_MUL_EN
  // One widened signed multiplier serves all four variants; signedness is chosen per operand.
  logic                     mulASigned;
  logic                     mulBSigned;
  logic signed [2*XLEN+1:0] mulA;
  logic signed [2*XLEN+1:0] mulB;
  logic signed [2*XLEN+1:0] mulProd;
  logic                     unusedMulBits;

  assign mulASigned    = (opcode == OP_MULH) || (opcode == OP_MULHSU);
  assign mulBSigned    = (opcode == OP_MULH);
  assign mulA          = {{(XLEN+2){mulASigned & opA[XLEN-1]}}, opA};
  assign mulB          = {{(XLEN+2){mulBSigned & opB[XLEN-1]}}, opB};
  assign mulProd       = mulA * mulB;
  assign unusedMulBits = ^mulProd[2*XLEN+1:2*XLEN];
`endif

  always_comb begin
    aluResult = '0;
    case (opcode)
      OP_ADD:   aluResult = opA + opB;
      OP_SLL:   aluResult = opA << shiftAmount;
      OP_SLT:   aluResult = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
      OP_SLTU:  aluResult = {{(XLEN-1){1'b0}}, (opA < opB)};
      OP_XOR:   aluResult = opA ^ opB;
      OP_SRL:   aluResult = opA >> shiftAmount;
      OP_OR:    aluResult = opA | opB;
      OP_AND:   aluResult = opA & opB;
      OP_SUB:   aluResult = opA - opB;
      OP_SRA:   aluResult = $unsigned($signed(opA) >>> shiftAmount);
      OP_LUI:   aluResult = opB;
      OP_AUIPC: aluResult = dispatch_PC_i + opB;
`ifdef INTEGER_LANE_MUL_EN
      OP_MUL:   aluResult = mulProd[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:
                aluResult = mulProd[2*XLEN-1:XLEN];
`endif
      default:  aluResult = '0;
    endcase
  end

  assign dispatch_ready = (occ_q < OCC_FULL) && !flush && !reset;
  assign accept         = dispatch_valid && dispatch_ready;
  assign fifoEmpty      = (wrPtr_q == rdPtr_q);
  assign headValid      = !fifoEmpty && !reset;
  assign execute_valid  = headValid && !flush;
  assign pop            = execute_valid && execute_ready;
  assign fifoWrite      = stageValid_q[PIPE_DEPTH-1];

  assign execute_ROB_index = headValid ? fifoTag_q[rdPtr_q[PTR_W-1:0]]   : '0;
  assign execute_value     = headValid ? fifoValue_q[rdPtr_q[PTR_W-1:0]] : '0;

  // Credits cover both pipeline and FIFO entries, so the final stage can always write.
  always_comb begin
    occ_d   = occ_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (accept && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (fifoWrite) begin
      wrPtr_d = wrPtr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      stageValid_q <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      occ_q        <= '0;
    end else begin
      stageValid_q[0] <= accept;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stageValid_q[i] <= stageValid_q[i-1];
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      occ_q   <= occ_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by stageValid_q and the pointers.
  always_ff @(posedge clock) begin
    stageTag_q[0]   <= dispatch_ROB_index;
    stageValue_q[0] <= aluResult;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      stageTag_q[i]   <= stageTag_q[i-1];
      stageValue_q[i] <= stageValue_q[i-1];
    end
    if (fifoWrite) begin
      fifoTag_q[wrPtr_q[PTR_W-1:0]]   <= stageTag_q[PIPE_DEPTH-1];
      fifoValue_q[wrPtr_q[PTR_W-1:0]] <= stageValue_q[PIPE_DEPTH-1];
    end
  end

endmodule

// File: tb/tb_integer_lane_pipelined.sv
// Directed testbench for integer_lane_pipelined: reset, op results, full/backpressure, flush, simultaneous accept/pop, multiplier opcodes.
module tb_integer_lane_pipelined;

  localparam int XLEN = 32;
  localparam int RW   = 8;
  localparam int DW   = 8;
  localparam int PD   = 2;
  localparam int FD   = 4;

  logic            clock;
  logic            reset;
  logic            dispatch_valid;
  logic            dispatch_ready;
  logic [XLEN-1:0] dispatch_1st_reg;
  logic [XLEN-1:0] dispatch_2nd_reg;
  logic [DW-1:0]   dispatch_decoded_instruction;
  logic [RW-1:0]   dispatch_ROB_index;
  logic [XLEN-1:0] dispatch_PC_i;
  logic            execute_ready;
  logic            execute_valid;
  logic [RW-1:0]   execute_ROB_index;
  logic [XLEN-1:0] execute_value;
  logic            flush;

  int vectors     = 0;
  int miscompares = 0;

  logic [XLEN-1:0] gotVal[$];
  logic [RW-1:0]   gotTag[$];

  integer_lane_pipelined #(
    .XLEN(XLEN), .ROB_INDEX_WIDTH(RW), .DECODED_INSTR_WIDTH(DW),
    .PIPE_DEPTH(PD), .OUT_FIFO_DEPTH(FD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dispatch_valid(dispatch_valid),
    .dispatch_ready(dispatch_ready),
    .dispatch_1st_reg(dispatch_1st_reg),
    .dispatch_2nd_reg(dispatch_2nd_reg),
    .dispatch_decoded_instruction(dispatch_decoded_instruction),
    .dispatch_ROB_index(dispatch_ROB_index),
    .dispatch_PC_i(dispatch_PC_i),
    .execute_ready(execute_ready),
    .execute_valid(execute_valid),
    .execute_ROB_index(execute_ROB_index),
    .execute_value(execute_value),
    .flush(flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [7:0] rob);
    dispatch_valid               = 1'b1;
    dispatch_decoded_instruction = {4'b0000, op};
    dispatch_1st_reg             = a;
    dispatch_2nd_reg             = b;
    dispatch_PC_i                = pc;
    dispatch_ROB_index           = rob;
  endtask

  task automatic sampleHead();
    if (execute_valid && execute_ready) begin
      gotVal.push_back(execute_value);
      gotTag.push_back(execute_ROB_index);
    end
  endtask

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0]  opList [5] = '{4'd8, 4'd6, 4'd9, 4'd2, 4'd11};
    logic [31:0] aList  [5] = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] bList  [5] = '{32'd6, 32'd8, 32'd4, 32'd1, 32'h20};
    logic [31:0] pcList [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h100};
    logic [31:0] expList[5] = '{32'd1, 32'd15, 32'hF800_0000, 32'd1, 32'h120};
    logic [31:0] mulExp [2];
    int          accepts;
    int          seen;
    int          waited;
    logic        readyNow;

    reset = 1'b1; flush = 1'b0; execute_ready = 1'b0; dispatch_valid = 1'b0;
    dispatch_1st_reg = '0; dispatch_2nd_reg = '0; dispatch_decoded_instruction = '0;
    dispatch_ROB_index = '0; dispatch_PC_i = '0;
    tick(); tick();
    checkOutput("readyDuringReset", 64'(dispatch_ready), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("resetReady", 64'(dispatch_ready), 64'd1);
    checkOutput("resetValid", 64'(execute_valid), 64'd0);
    checkOutput("resetRob", 64'(execute_ROB_index), 64'd0);
    checkOutput("resetValue", 64'(execute_value), 64'd0);

    // Single ADD latency and one-cycle visibility
    execute_ready = 1'b1;
    applyStimulus(4'd0, 32'd17, 32'd18, 32'd0, 8'd11);
    tick();
    dispatch_valid = 1'b0;
    for (int c = 0; c < PD; c++) begin
      checkOutput("addEarly", 64'(execute_valid), 64'd0);
      tick();
    end
    checkOutput("addValid", 64'(execute_valid), 64'd1);
    checkOutput("addValue", 64'(execute_value), 64'd35);
    checkOutput("addRob", 64'(execute_ROB_index), 64'd11);
    tick();
    checkOutput("addOneCycle", 64'(execute_valid), 64'd0);

    // Back-to-back mixed ops, results in order
    gotVal.delete(); gotTag.delete();
    for (int c = 0; c < 20; c++) begin
      if (c < 5) begin
        applyStimulus(opList[c], aList[c], bList[c], pcList[c], 8'(12 + c));
        #1;
        checkOutput("opsReady", 64'(dispatch_ready), 64'd1);
      end else begin
        dispatch_valid = 1'b0;
      end
      tick();
      sampleHead();
    end
    checkOutput("opsCount", 64'(gotVal.size()), 64'd5);
    for (int i = 0; i < gotVal.size() && i < 5; i++) begin
      checkOutput($sformatf("opsValue%0d", i), 64'(gotVal[i]), 64'(expList[i]));
      checkOutput($sformatf("opsRob%0d", i), 64'(gotTag[i]), 64'(12 + i));
    end

    // Full: execute_ready low, continuous dispatch
    execute_ready = 1'b0;
    accepts = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'd0, 32'(accepts + 1), 32'(accepts + 2), 32'd0, 8'(20 + accepts));
      #1;
      readyNow = dispatch_ready;
      tick();
      if (readyNow) accepts++;
    end
    dispatch_valid = 1'b0;
    checkOutput("fullAccepts", 64'(accepts), 64'(FD));
    checkOutput("fullReadyLow", 64'(dispatch_ready), 64'd0);
    execute_ready = 1'b1;
    #1;
    checkOutput("fullReadyNotComb", 64'(dispatch_ready), 64'd0);
    gotVal.delete(); gotTag.delete();
    sampleHead();
    tick();
    checkOutput("fullReadyAfterPop", 64'(dispatch_ready), 64'd1);
    for (int c = 0; c < 10; c++) begin
      sampleHead();
      tick();
    end
    checkOutput("drainCount", 64'(gotVal.size()), 64'(FD));
    for (int i = 0; i < gotVal.size() && i < FD; i++) begin
      checkOutput($sformatf("drainValue%0d", i), 64'(gotVal[i]), 64'(2 * i + 3));
      checkOutput($sformatf("drainRob%0d", i), 64'(gotTag[i]), 64'(20 + i));
    end

    // Flush with two entries in the pipeline and two in the FIFO
    execute_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(4'd0, 32'(100 + n), 32'd0, 32'd0, 8'(40 + n));
      tick();
    end
    flush = 1'b1;
    applyStimulus(4'd0, 32'd5, 32'd5, 32'd0, 8'd99);
    #1;
    checkOutput("flushReadyLow", 64'(dispatch_ready), 64'd0);
    checkOutput("flushValidLow", 64'(execute_valid), 64'd0);
    tick();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    #1;
    checkOutput("flushReadyBack", 64'(dispatch_ready), 64'd1);
    checkOutput("flushEmpty", 64'(execute_valid), 64'd0);
    execute_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (execute_valid) seen++;
      tick();
    end
    checkOutput("flushNoResults", 64'(seen), 64'd0);
    applyStimulus(4'd0, 32'd1, 32'd2, 32'd0, 8'd33);
    tick();
    dispatch_valid = 1'b0;
    waited = 0;
    while (!execute_valid && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput("postFlushValid", 64'(execute_valid), 64'd1);
    checkOutput("postFlushValue", 64'(execute_value), 64'd3);
    checkOutput("postFlushRob", 64'(execute_ROB_index), 64'd33);
    tick();

    // Simultaneous accept and pop at occ == FD-1
    execute_ready = 1'b0;
    for (int n = 0; n < FD - 1; n++) begin
      applyStimulus(4'd0, 32'(n), 32'd10, 32'd0, 8'(50 + n));
      tick();
    end
    dispatch_valid = 1'b0;
    tick(); tick(); tick();
    checkOutput("simulPreReady", 64'(dispatch_ready), 64'd1);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 8'd53);
    execute_ready = 1'b1;
    #1;
    checkOutput("simulPopValid", 64'(execute_valid), 64'd1);
    tick();
    execute_ready = 1'b0;
    dispatch_valid = 1'b0;
    #1;
    checkOutput("simulReadyKept", 64'(dispatch_ready), 64'd1);
    applyStimulus(4'd0, 32'd1, 32'd1, 32'd0, 8'd54);
    tick();
    dispatch_valid = 1'b0;
    #1;
    checkOutput("simulFullAfterOne", 64'(dispatch_ready), 64'd0);

    // Reset mid-operation forces outputs low
    reset = 1'b1;
    #1;
    checkOutput("midResetValid", 64'(execute_valid), 64'd0);
    checkOutput("midResetValue", 64'(execute_value), 64'd0);
    checkOutput("midResetRob", 64'(execute_ROB_index), 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    checkOutput("midResetEmpty", 64'(execute_valid), 64'd0);
    checkOutput("midResetReady", 64'(dispatch_ready), 64'd1);

    // Multiplier opcodes, expectation depends on build option
`ifdef INTEGER_LANE_MUL_EN
    mulExp[0] = 32'hFFFF_FFFE;
    mulExp[1] = 32'd1;
`else
    mulExp[0] = 32'd0;
    mulExp[1] = 32'd0;
`endif
    execute_ready = 1'b1;
    gotVal.delete(); gotTag.delete();
    applyStimulus(4'd12, 32'hFFFF_FFFF, 32'd2, 32'd0, 8'd60);
    tick();
    applyStimulus(4'd14, 32'hFFFF_FFFF, 32'd2, 32'd0, 8'd61);
    tick();
    dispatch_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sampleHead();
      tick();
    end
    checkOutput("mulCount", 64'(gotVal.size()), 64'd2);
    for (int i = 0; i < gotVal.size() && i < 2; i++) begin
      checkOutput($sformatf("mulValue%0d", i), 64'(gotVal[i]), 64'(mulExp[i]));
      checkOutput($sformatf("mulRob%0d", i), 64'(gotTag[i]), 64'(60 + i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
